// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Clock cycles per oversample tick, truncated.
  function automatic int calc_div(input int clk_mhz, input int baudrate, input int oversample);
    return (clk_mhz * 1_000_000) / (baudrate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, re-phased on resync.
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic resync,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Down-counter reloads at terminal count or when re-phased by a start edge.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (resync || (cnt_q == '0)) cnt_d = CNT_LOAD;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0) && !resync;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronised, oversampled, majority-voted bits with ready/valid output.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a 1->0 edge
// ST_START     | qualifying the start bit (majority 1 = glitch)
// ST_DATA      | shifting payload bits, LSB first
// ST_PARITY    | checking the parity bit
// ST_STOP      | checking stop bit(s); frame completes at last sample
// ST_WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_MHZ    = 50,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_MHZ, BAUDRATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DB_LAST   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_core: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_rx_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_core: OVERSAMPLE must be even, 8..16");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_core: clock too slow for BAUDRATE*OVERSAMPLE");
  end

  uart_state_e          state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s, rx_prev_q, fall;
  logic                 tick, resync, done, majority, sample3, bit_end, done_ferr;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d, ovr_q, ovr_d, accept;

  assign rx_s = sync_q[1];
  assign fall = rx_prev_q & ~rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .resync (resync),
    .tick   (tick)
  );

  // Two-flop synchroniser plus edge-detect history; idle-high after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
    end
  end

  // Receive FSM: tick counting, 3-sample majority, bit sequencing.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    resync    = 1'b0;
    done      = 1'b0;
    majority  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    sample3   = tick && (tcnt_q == T_S2);
    bit_end   = tick && (tcnt_q == T_END);
    done_ferr = ferr_q | ~majority;

    if (state_q != ST_IDLE && state_q != ST_WAIT_HIGH && tick) begin
      tcnt_d = bit_end ? '0 : tcnt_q + 1'b1;
      if (tcnt_q == T_S0) samp_d[0] = rx_s;
      if (tcnt_q == T_S1) samp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          tcnt_d  = '0;
          resync  = 1'b1;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (sample3 && majority) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
          bcnt_d  = '0;
        end
      end
      ST_DATA: begin
        if (sample3) shift_d = {majority, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bcnt_q == DB_LAST) begin
            bcnt_d  = '0;
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (sample3) begin
          if (PARITY == PAR_EVEN) perr_d = ^shift_q ^ majority;
          else                    perr_d = ~(^shift_q ^ majority);
        end
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (sample3) begin
          if (!majority) ferr_d = 1'b1;
          if (bcnt_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = done_ferr ? ST_WAIT_HIGH : ST_IDLE;
          end
        end
        if (bit_end) bcnt_d = bcnt_q + 1'b1;
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output holding register: load on completion unless an unaccepted frame is held.
  always_comb begin
    accept     = valid_q & ready;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done) begin
      if (!valid_q || accept) begin
        data_d     = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = done_ferr;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench: 8N1 and 7E2 receivers, expected frames queued at send time.
module tb_uart_rx_core;

  localparam int BIT = 64;  // clocks per bit: DIV 4 x OVERSAMPLE 16

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx8, rx7, ready8, ready7;
  logic [7:0] data8;
  logic [6:0] data7;
  logic       valid8, perr8, ferr8, ovr8, busy8;
  logic       valid7, perr7, ferr7, ovr7, busy7;

  int   checks = 0;
  int   errors = 0;
  int   n8 = 0, n7 = 0, hs8 = 0, hs7 = 0;
  exp_t q8[$];
  exp_t q7[$];
  exp_t e8, e7;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_MHZ(1), .BAUDRATE(15625), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx8), .data(data8), .valid(valid8), .ready(ready8),
    .parity_err(perr8), .frame_err(ferr8), .overrun(ovr8), .busy(busy8)
  );

  uart_rx_core #(
    .CLK_MHZ(1), .BAUDRATE(15625), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)
  ) dut7 (
    .clk(clk), .rst(rst), .rx(rx7), .data(data7), .valid(valid7), .ready(ready7),
    .parity_err(perr7), .frame_err(ferr7), .overrun(ovr7), .busy(busy7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push8(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe;
    q8.push_back(e);
    n8++;
  endtask

  task automatic push7(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe;
    q7.push_back(e);
    n7++;
  endtask

  // Drives one frame starting at a falling clock edge; one loop pass per clock.
  task automatic send(input bit to7, input logic [8:0] val, input int nbits, input int par,
                      input bit flip, input int nstop, input logic stop_v,
                      input int glitch_c, input int rdy_c);
    logic bits[$];
    logic p;
    logic b;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      bits.push_back(val[i]);
      p = p ^ val[i];
    end
    if (par != 0) bits.push_back(((par == 2) ? ~p : p) ^ flip);
    for (int i = 0; i < nstop; i++) bits.push_back(stop_v);
    for (int c = 0; c < bits.size() * BIT; c++) begin
      b = bits[c / BIT];
      if (c == glitch_c) b = ~b;
      if (to7) rx7 = b;
      else     rx8 = b;
      if (c == rdy_c) ready8 = 1'b1;
      if (rdy_c >= 0 && c == rdy_c + 1) ready8 = 1'b0;
      @(negedge clk);
    end
  endtask

  // Scoreboard for the 8N1 receiver: compare on every accepted handshake.
  always @(negedge clk) begin
    #1;
    if (valid8 && ready8) begin
      hs8++;
      if (q8.size() == 0) begin
        chk("dut8_spurious_valid", 32'(valid8), 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("dut8_data", 32'(data8), 32'(e8.data[7:0]));
        chk("dut8_parity_err", 32'(perr8), 32'(e8.perr));
        chk("dut8_frame_err", 32'(ferr8), 32'(e8.ferr));
      end
    end
  end

  // Scoreboard for the 7E2 receiver.
  always @(negedge clk) begin
    #1;
    if (valid7 && ready7) begin
      hs7++;
      if (q7.size() == 0) begin
        chk("dut7_spurious_valid", 32'(valid7), 32'd0);
      end else begin
        e7 = q7.pop_front();
        chk("dut7_data", 32'(data7), 32'(e7.data[6:0]));
        chk("dut7_parity_err", 32'(perr7), 32'(e7.perr));
        chk("dut7_frame_err", 32'(ferr7), 32'(e7.ferr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rx8 = 1'b1; rx7 = 1'b1; ready8 = 1'b1; ready7 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data8), 32'd0);
    chk("rst_valid", 32'(valid8), 32'd0);
    chk("rst_perr", 32'(perr8), 32'd0);
    chk("rst_ferr", 32'(ferr8), 32'd0);
    chk("rst_overrun", 32'(ovr8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_valid7", 32'(valid7), 32'd0);
    chk("rst_busy7", 32'(busy7), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 basic frame
    push8(9'h0A5, 1'b0, 1'b0);
    send(1'b0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    chk("a5_handshakes", 32'(hs8), 32'(n8));

    // single-sample glitch at the centre of data bit 3 of 0x00
    push8(9'h000, 1'b0, 1'b0);
    send(1'b0, 9'h000, 8, 0, 1'b0, 1, 1'b1, 4 * BIT + 36, -1);

    // 3-tick low pulse while idle is rejected as a glitch
    rx8 = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_busy_high", 32'(busy8), 32'd1);
    repeat (4) @(negedge clk);
    rx8 = 1'b1;
    repeat (52) @(negedge clk);
    chk("glitch_busy_low", 32'(busy8), 32'd0);
    chk("glitch_no_valid", 32'(hs8), 32'(n8));

    // stop bit low: framing error, then hold in WAIT_HIGH while the line stays low
    push8(9'h081, 1'b0, 1'b1);
    send(1'b0, 9'h081, 8, 0, 1'b0, 1, 1'b0, -1, -1);
    repeat (200) @(negedge clk);
    chk("wait_high_busy", 32'(busy8), 32'd1);
    rx8 = 1'b1;
    repeat (6) @(negedge clk);
    chk("wait_high_release", 32'(busy8), 32'd0);
    push8(9'h055, 1'b0, 1'b0);
    send(1'b0, 9'h055, 8, 0, 1'b0, 1, 1'b1, -1, -1);

    // overrun: second frame discarded while the first is held
    ready8 = 1'b0;
    push8(9'h011, 1'b0, 1'b0);
    send(1'b0, 9'h011, 8, 0, 1'b0, 1, 1'b1, -1, -1);
    send(1'b0, 9'h022, 8, 0, 1'b0, 1, 1'b1, -1, -1);
    chk("ovr_valid", 32'(valid8), 32'd1);
    chk("ovr_data_held", 32'(data8), 32'h11);
    chk("ovr_flag", 32'(ovr8), 32'd1);
    ready8 = 1'b1;
    @(negedge clk);
    ready8 = 1'b0;
    @(negedge clk);
    chk("ovr_valid_after_accept", 32'(valid8), 32'd0);
    chk("ovr_cleared", 32'(ovr8), 32'd0);

    // completion coincides with acceptance of the held frame
    push8(9'h03A, 1'b0, 1'b0);
    send(1'b0, 9'h03A, 8, 0, 1'b0, 1, 1'b1, -1, -1);
    push8(9'h0C4, 1'b0, 1'b0);
    send(1'b0, 9'h0C4, 8, 0, 1'b0, 1, 1'b1, -1, 618);
    chk("same_cycle_valid", 32'(valid8), 32'd1);
    chk("same_cycle_data", 32'(data8), 32'hC4);
    chk("same_cycle_no_ovr", 32'(ovr8), 32'd0);
    ready8 = 1'b1;
    repeat (3) @(negedge clk);

    // reset in the middle of the data bits
    ready8 = 1'b0;
    send(1'b0, 9'h05A, 8, 0, 1'b0, 1, 1'b1, -1, -1);
    chk("pre_rst_valid", 32'(valid8), 32'd1);
    chk("pre_rst_data", 32'(data8), 32'h5A);
    rx8 = 1'b0;
    repeat (4 * BIT + 20) @(negedge clk);
    chk("pre_rst_busy", 32'(busy8), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_data", 32'(data8), 32'd0);
    chk("mid_rst_valid", 32'(valid8), 32'd0);
    chk("mid_rst_perr", 32'(perr8), 32'd0);
    chk("mid_rst_ferr", 32'(ferr8), 32'd0);
    chk("mid_rst_overrun", 32'(ovr8), 32'd0);
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    rx8 = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (700) @(negedge clk);
    chk("post_rst_busy", 32'(busy8), 32'd0);
    chk("post_rst_valid", 32'(valid8), 32'd0);
    ready8 = 1'b1;

    // 7E2: correct parity then flipped parity
    push7(9'h03C, 1'b0, 1'b0);
    send(1'b1, 9'h03C, 7, 1, 1'b0, 2, 1'b1, -1, -1);
    push7(9'h03C, 1'b1, 1'b0);
    send(1'b1, 9'h03C, 7, 1, 1'b1, 2, 1'b1, -1, -1);

    repeat (20) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q7_drained", 32'(q7.size()), 32'd0);
    chk("hs8_count", 32'(hs8), 32'(n8));
    chk("hs7_count", 32'(hs7), 32'(n7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
